// File: rtl/pad_cfg_regbank_pkg.sv
// pkg_pad_cfg_regbank: register map, field positions, bus structs and FSM states
// for the pad-mux configuration register bank.
package pkg_pad_cfg_regbank;

    localparam logic [31:0] INFO_OFS   = 32'h000;
    localparam logic [31:0] CTRL_OFS   = 32'h004;
    localparam logic [31:0] STATUS_OFS = 32'h008;
    localparam logic [31:0] PADCFG_OFS = 32'h100;

    localparam int CTRL_COMMIT  = 0;
    localparam int CTRL_LOCK    = 1;
    localparam int CTRL_DISCARD = 2;

    localparam int ST_PENDING = 0;
    localparam int ST_LOCKED  = 1;
    localparam int ST_BUSY    = 2;

    localparam int SEL_LSB = 0;
    localparam int CFG_LSB = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } cfg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } cfg_rsp_t;

    typedef enum logic [1:0] {IDLE, RESP, PARK, APPLY} state_e;

endpackage

// File: rtl/pad_cfg_slot.sv
// pad_cfg_slot: one pad's shadow/active register pair.
// Ports: clk_i/rst_i clock and async reset; we/wsel/wcfg strobed shadow write;
// discard copies active into shadow; apply copies shadow into active;
// park forces sel_o to 0 when the pad is about to change; shadow_* expose the
// shadow for readback; sel_o/cfg_o drive the padframe; diff flags shadow != active.
module pad_cfg_slot #(
    parameter int SEL_W = 4,
    parameter int CFG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we,
    input  logic [SEL_W-1:0] wsel,
    input  logic [CFG_W-1:0] wcfg,
    input  logic             discard,
    input  logic             apply,
    input  logic             park,
    output logic [SEL_W-1:0] shadow_sel,
    output logic [CFG_W-1:0] shadow_cfg,
    output logic [SEL_W-1:0] sel_o,
    output logic [CFG_W-1:0] cfg_o,
    output logic             diff
);

    logic [SEL_W-1:0] act_sel;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_sel <= '0;
            shadow_cfg <= '0;
            act_sel    <= '0;
            cfg_o      <= '0;
        end else begin
            if (discard) begin
                shadow_sel <= act_sel;
                shadow_cfg <= cfg_o;
            end else if (we) begin
                shadow_sel <= wsel;
                shadow_cfg <= wcfg;
            end
            if (apply) begin
                act_sel <= shadow_sel;
                cfg_o   <= shadow_cfg;
            end
        end
    end

    assign diff  = (shadow_sel != act_sel) || (shadow_cfg != cfg_o);
    // break-before-make: a pad whose mux select will change is disconnected first
    assign sel_o = (park && shadow_sel != act_sel) ? '0 : act_sel;

endmodule

// File: rtl/pad_cfg_regbank.sv
// pad_cfg_regbank: double-buffered pad-mux configuration bank with atomic,
// break-before-make commit, lock and error reporting.
// Ports: clk_i/rst_i clock and async reset; cfg_req_i/cfg_rsp_o config bus;
// pad_sel_o/pad_cfg_o per-pad active select and config; commit_busy_o high
// during PARK/APPLY; locked_o lock state.
module pad_cfg_regbank
    import pkg_pad_cfg_regbank::*;
#(
    parameter int          NUM_PADS    = 32,
    parameter int          NUM_PORTS   = 8,
    parameter int          CFG_W       = 8,
    parameter int          PARK_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter type         req_t       = cfg_req_t,
    parameter type         resp_t      = cfg_rsp_t,
    localparam int         SEL_W       = $clog2(NUM_PORTS + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  req_t                            cfg_req_i,
    output resp_t                           cfg_rsp_o,
    output logic [NUM_PADS-1:0][SEL_W-1:0]  pad_sel_o,
    output logic [NUM_PADS-1:0][CFG_W-1:0]  pad_cfg_o,
    output logic                            commit_busy_o,
    output logic                            locked_o
);

    localparam int IDX_W = NUM_PADS > 1 ? $clog2(NUM_PADS) : 1;

    state_e                        state_q, state_d;
    logic [3:0]                    cnt_q;
    logic                          commit_q, discard_q, locked_q, err_q;
    logic [31:0]                   rdata_q;
    logic [NUM_PADS-1:0][SEL_W-1:0] sh_sel;
    logic [NUM_PADS-1:0][CFG_W-1:0] sh_cfg;
    logic [NUM_PADS-1:0]           diff;

    logic [31:0]      off, cur, merged, rdata;
    logic [IDX_W-1:0] idx;
    logic [2:0]       ctl;
    logic             is_info, is_ctrl, is_stat, is_pad, wr, sel_bad, err, accept, busy;

    assign off     = cfg_req_i.addr - BASE_ADDR;
    assign is_info = off == INFO_OFS;
    assign is_ctrl = off == CTRL_OFS;
    assign is_stat = off == STATUS_OFS;
    assign is_pad  = off >= PADCFG_OFS && off < PADCFG_OFS + 32'(4 * NUM_PADS) && off[1:0] == 2'b00;
    assign idx     = off[IDX_W+1:2];
    assign cur     = 32'({sh_cfg[idx], 8'(sh_sel[idx])});
    assign wr      = cfg_req_i.write;
    assign ctl     = cfg_req_i.wdata[2:0] & {3{cfg_req_i.wstrb[0]}};
    assign busy    = state_q == PARK || state_q == APPLY;

    always_comb begin
        merged = cur;
        for (int b = 0; b < 4; b++)
            merged[8*b +: 8] = cfg_req_i.wstrb[b] ? cfg_req_i.wdata[8*b +: 8] : cur[8*b +: 8];
    end

    // lock is sampled before this write, so COMMIT+LOCK still commits
    assign sel_bad = merged[SEL_LSB +: 8] > 8'(NUM_PORTS);
    assign err = !(is_info || is_ctrl || is_stat || is_pad)
              || (wr && (is_info || is_stat))
              || (wr && is_pad && (sel_bad || locked_q))
              || (wr && is_ctrl && ((locked_q && (ctl[CTRL_COMMIT] || ctl[CTRL_DISCARD]))
                                    || (ctl[CTRL_COMMIT] && ctl[CTRL_DISCARD])));
    assign rdata = (err || wr) ? '0
                 : is_info ? {16'(NUM_PORTS), 16'(NUM_PADS)}
                 : is_stat ? {29'b0, busy, locked_q, |diff}
                 : is_pad  ? cur : '0;
    assign accept = state_q == IDLE && cfg_req_i.valid && !err;

    assign state_d = state_q == IDLE ? (cfg_req_i.valid ? RESP : IDLE)
                   : state_q == RESP ? (commit_q ? PARK : IDLE)
                   : state_q == PARK ? (cnt_q == 4'd1 ? APPLY : PARK)
                   : IDLE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            commit_q  <= 1'b0;
            discard_q <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cfg_req_i.valid) begin
                rdata_q   <= rdata;
                err_q     <= err;
                commit_q  <= accept && wr && is_ctrl && ctl[CTRL_COMMIT];
                discard_q <= accept && wr && is_ctrl && ctl[CTRL_DISCARD];
                if (accept && wr && is_ctrl && ctl[CTRL_LOCK])
                    locked_q <= 1'b1;
            end
            cnt_q <= state_q == RESP ? 4'(PARK_CYCLES) : state_q == PARK ? cnt_q - 4'd1 : cnt_q;
        end
    end

    always_comb begin
        cfg_rsp_o = '0;
        if (state_q == RESP) begin
            cfg_rsp_o.rdata = rdata_q;
            cfg_rsp_o.error = err_q;
            cfg_rsp_o.ready = 1'b1;
        end
    end

    assign commit_busy_o = busy;
    assign locked_o      = locked_q;

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_slot
        // parking also covers APPLY so a changing pad never shows its old select again
        pad_cfg_slot #(.SEL_W(SEL_W), .CFG_W(CFG_W)) u_slot (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .we         (accept && wr && is_pad && idx == IDX_W'(i)),
            .wsel       (merged[SEL_LSB +: SEL_W]),
            .wcfg       (merged[CFG_LSB +: CFG_W]),
            .discard    (discard_q && state_q == RESP),
            .apply      (state_q == APPLY),
            .park       (busy),
            .shadow_sel (sh_sel[i]),
            .shadow_cfg (sh_cfg[i]),
            .sel_o      (pad_sel_o[i]),
            .cfg_o      (pad_cfg_o[i]),
            .diff       (diff[i])
        );
    end

endmodule

// File: tb/tb_pad_cfg_regbank.sv
// tb_pad_cfg_regbank: directed self-checking bench for pad_cfg_regbank.
module tb_pad_cfg_regbank;
    import pkg_pad_cfg_regbank::*;

    localparam int SEL_W = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    cfg_req_t req = '0;
    cfg_rsp_t rsp;
    logic [31:0][SEL_W-1:0] pad_sel;
    logic [31:0][7:0]       pad_cfg;
    logic busy, locked;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    pad_cfg_regbank #(
        .NUM_PADS(32), .NUM_PORTS(8), .CFG_W(8), .PARK_CYCLES(2), .BASE_ADDR(32'h0)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cfg_req_i     (req),
        .cfg_rsp_o     (rsp),
        .pad_sel_o     (pad_sel),
        .pad_cfg_o     (pad_cfg),
        .commit_busy_o (busy),
        .locked_o      (locked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one bus transaction; returns #1 into the RESP cycle
    task automatic xact(input string tag, input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_err);
        @(posedge clk_i);
        @(negedge clk_i);
        req.addr = a; req.write = w; req.wdata = d; req.wstrb = s; req.valid = 1'b1;
        @(posedge clk_i);
        #1;
        chk({tag, ".ready"}, 32'(rsp.ready), 32'd1);
        chk({tag, ".error"}, 32'(rsp.error), 32'(exp_err));
        chk({tag, ".rdata"}, rsp.rdata, exp_rd);
        req = '0;
    endtask

    // follows a commit from its RESP cycle: 2 PARK + 1 APPLY, then new values
    task automatic watch(input string tag, input int p, input logic [3:0] newv, input int q, input logic [3:0] qv);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("%s.busy%0d", tag, k), 32'(busy), 32'(k < 4));
            chk($sformatf("%s.sel%0d", tag, k), 32'(pad_sel[p]), 32'(k < 4 ? 4'd0 : newv));
            chk($sformatf("%s.other%0d", tag, k), 32'(pad_sel[q]), 32'(qv));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst.sel", 32'(|pad_sel), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.locked", 32'(locked), 32'd0);
        chk("rst.rsp", 32'(rsp.ready) | rsp.rdata, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        xact("info", 32'h000, 1'b0, 0, 4'h0, 32'h0008_0020, 1'b0);

        xact("wr4", 32'h110, 1'b1, 32'h0000_3305, 4'hF, 32'h0, 1'b0);
        xact("c4", 32'h004, 1'b1, 32'h1, 4'h1, 32'h0, 1'b0);
        watch("c4", 4, 4'd5, 3, 4'd0);
        chk("c4.cfg", 32'(pad_cfg[4]), 32'h33);

        xact("wr3a", 32'h10C, 1'b1, 32'h0000_0001, 4'hF, 32'h0, 1'b0);
        xact("c3a", 32'h004, 1'b1, 32'h1, 4'h1, 32'h0, 1'b0);
        watch("c3a", 3, 4'd1, 4, 4'd5);

        xact("wr3b", 32'h10C, 1'b1, 32'h0000_5A02, 4'hF, 32'h0, 1'b0);
        xact("rd3b", 32'h10C, 1'b0, 0, 4'h0, 32'h0000_5A02, 1'b0);
        chk("pre.sel3", 32'(pad_sel[3]), 32'd1);
        xact("stat.pend", 32'h008, 1'b0, 0, 4'h0, 32'h1, 1'b0);
        xact("c3b", 32'h004, 1'b1, 32'h1, 4'h1, 32'h0, 1'b0);
        watch("c3b", 3, 4'd2, 4, 4'd5);
        chk("c3b.cfg", 32'(pad_cfg[3]), 32'h5A);
        xact("stat.clean", 32'h008, 1'b0, 0, 4'h0, 32'h0, 1'b0);

        xact("c.nodiff", 32'h004, 1'b1, 32'h1, 4'h1, 32'h0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("nodiff.busy%0d", k), 32'(busy), 32'(k < 4));
            chk($sformatf("nodiff.sel%0d", k), 32'(pad_sel[3]), 32'd2);
        end

        xact("sel9", 32'h114, 1'b1, 32'h0000_0009, 4'hF, 32'h0, 1'b1);
        xact("rd5", 32'h114, 1'b0, 0, 4'h0, 32'h0, 1'b0);
        xact("misal", 32'h102, 1'b0, 0, 4'h0, 32'h0, 1'b1);
        xact("unmap", 32'h200, 1'b0, 0, 4'h0, 32'h0, 1'b1);
        xact("last", 32'h17C, 1'b0, 0, 4'h0, 32'h0, 1'b0);
        xact("past", 32'h180, 1'b0, 0, 4'h0, 32'h0, 1'b1);
        xact("wr.info", 32'h000, 1'b1, 32'h1, 4'hF, 32'h0, 1'b1);
        xact("ctrl.rd", 32'h004, 1'b0, 0, 4'h0, 32'h0, 1'b0);
        xact("strb", 32'h114, 1'b1, 32'hFFFF_7703, 4'h1, 32'h0, 1'b0);
        xact("rd.strb", 32'h114, 1'b0, 0, 4'h0, 32'h0000_0003, 1'b0);
        xact("cmt+dis", 32'h004, 1'b1, 32'h5, 4'h1, 32'h0, 1'b1);
        @(posedge clk_i);
        #1;
        chk("cmt+dis.busy", 32'(busy), 32'd0);
        xact("discard", 32'h004, 1'b1, 32'h4, 4'h1, 32'h0, 1'b0);
        xact("rd.disc", 32'h114, 1'b0, 0, 4'h0, 32'h0, 1'b0);
        xact("stat.disc", 32'h008, 1'b0, 0, 4'h0, 32'h0, 1'b0);

        xact("wr3c", 32'h10C, 1'b1, 32'h0000_0004, 4'hF, 32'h0, 1'b0);
        xact("c3c", 32'h004, 1'b1, 32'h3, 4'h1, 32'h0, 1'b0);
        chk("c3c.locked", 32'(locked), 32'd1);
        @(posedge clk_i);
        #1;
        chk("park.busy", 32'(busy), 32'd1);
        chk("park.sel3", 32'(pad_sel[3]), 32'd0);
        #2 rst_i = 1'b1;
        #1;
        chk("arst.sel", 32'(|pad_sel), 32'd0);
        chk("arst.cfg", 32'(|pad_cfg), 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.locked", 32'(locked), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        xact("post.info", 32'h000, 1'b0, 0, 4'h0, 32'h0008_0020, 1'b0);
        xact("post.rd3", 32'h10C, 1'b0, 0, 4'h0, 32'h0, 1'b0);

        xact("wr6", 32'h118, 1'b1, 32'h0000_0007, 4'hF, 32'h0, 1'b0);
        xact("c6", 32'h004, 1'b1, 32'h3, 4'h1, 32'h0, 1'b0);
        chk("c6.locked", 32'(locked), 32'd1);
        watch("c6", 6, 4'd7, 4, 4'd0);
        xact("lk.wr", 32'h118, 1'b1, 32'h0000_0001, 4'hF, 32'h0, 1'b1);
        xact("lk.rd", 32'h118, 1'b0, 0, 4'h0, 32'h7, 1'b0);
        xact("lk.cmt", 32'h004, 1'b1, 32'h1, 4'h1, 32'h0, 1'b1);
        xact("lk.lock", 32'h004, 1'b1, 32'h2, 4'h1, 32'h0, 1'b0);
        xact("lk.stat", 32'h008, 1'b0, 0, 4'h0, 32'h2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
